// File: rtl/n_rd_addr_gen.sv
// rtl/n_rd_addr_gen.sv - read address sequencer (single/circular, inc/dec, hold, abort)
// Optional feature macro: N_RD_ADDR_REPEAT_EN adds rep_cnt and a pass counter
// so that single-pass mode runs rep_cnt+1 passes before completing.
// All state updates on the falling edge of clkin; reset is asynchronous, active-low.
module n_rd_addr_gen #(
  parameter int ADDR_W = 12,
  parameter int REP_W  = 8
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  input  logic              mode,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
`ifdef N_RD_ADDR_REPEAT_EN
  input  logic [REP_W-1:0]  rep_cnt,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              addr_vld,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_vld;
  logic [ADDR_W-1:0] r_rem;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
  logic              r_mode;
  logic              r_dir;
  logic              w_start_ok;
  logic              w_last;
  logic              w_more;
  logic [ADDR_W-1:0] w_step;

  assign w_start_ok = start && (len != '0);
  assign w_last     = (r_rem == '0);
  assign w_step     = r_dir ? (r_addr - ONE) : (r_addr + ONE);

`ifdef N_RD_ADDR_REPEAT_EN
  logic [REP_W-1:0] r_pass;
  // another pass follows in circular mode or while repeat passes remain
  assign w_more = r_mode || (r_pass != '0);
`else
  assign w_more = r_mode;
`endif

  // state register
  always_ff @(negedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic; abort overrides everything else
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start_ok) w_next = S_RUN;
        S_RUN:   if (!hold && w_last && !w_more) w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // state-decoded outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // address datapath: latch config at start, step/reload/freeze while running
  always_ff @(negedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_vld  <= 1'b0;
      r_rem  <= '0;
      r_base <= '0;
      r_len  <= '0;
      r_mode <= 1'b0;
      r_dir  <= 1'b0;
`ifdef N_RD_ADDR_REPEAT_EN
      r_pass <= '0;
`endif
    end else if (abort) begin
      r_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_base <= base_addr;
            r_len  <= len;
            r_mode <= mode;
            r_dir  <= dir;
            r_addr <= base_addr;
            r_rem  <= len - ONE;
            r_vld  <= 1'b1;
`ifdef N_RD_ADDR_REPEAT_EN
            r_pass <= rep_cnt;
`endif
          end else begin
            r_vld <= 1'b0;
          end
        end
        S_RUN: begin
          if (hold) begin
            r_vld <= 1'b0;
          end else if (!w_last) begin
            r_addr <= w_step;
            r_rem  <= r_rem - ONE;
            r_vld  <= 1'b1;
          end else if (w_more) begin
            r_addr <= r_base;
            r_rem  <= r_len - ONE;
            r_vld  <= 1'b1;
`ifdef N_RD_ADDR_REPEAT_EN
            if (!r_mode) r_pass <= r_pass - REP_W'(1);
`endif
          end else begin
            r_vld <= 1'b0;
          end
        end
        default: begin
          r_vld <= 1'b0;
        end
      endcase
    end
  end

  assign addr     = r_addr;
  assign addr_vld = r_vld;

endmodule

// File: tb/tb_n_rd_addr_gen.sv
// tb/tb_n_rd_addr_gen.sv - directed self-checking bench for n_rd_addr_gen
module tb_n_rd_addr_gen;

  logic        clkin;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        hold;
  logic        mode;
  logic        dir;
  logic [11:0] base_addr;
  logic [11:0] len;
`ifdef N_RD_ADDR_REPEAT_EN
  logic [7:0]  rep_cnt;
`endif
  logic [11:0] addr;
  logic        addr_vld;
  logic        busy;
  logic        done;

  int n_tests;
  int n_fail;

  n_rd_addr_gen #(.ADDR_W(12), .REP_W(8)) u_dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .hold      (hold),
    .mode      (mode),
    .dir       (dir),
    .base_addr (base_addr),
    .len       (len),
`ifdef N_RD_ADDR_REPEAT_EN
    .rep_cnt   (rep_cnt),
`endif
    .addr      (addr),
    .addr_vld  (addr_vld),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clkin = 1'b1;
    forever #5 clkin = ~clkin;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // DUT updates on the falling edge; outputs are sampled on the rising edge
  task automatic step();
    @(negedge clkin);
    @(posedge clkin);
  endtask

  task automatic go(input logic [11:0] b, input logic [11:0] l, input logic m, input logic d);
    base_addr = b;
    len       = l;
    mode      = m;
    dir       = d;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic expect_a(input string tag, input logic [11:0] a);
    chk({tag, ".addr"}, addr, a);
    chk({tag, ".vld"}, addr_vld, 1);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".done"}, done, 0);
    step();
  endtask

  task automatic expect_done(input string tag, input logic [11:0] a);
    chk({tag, ".dn_addr"}, addr, a);
    chk({tag, ".dn_vld"}, addr_vld, 0);
    chk({tag, ".dn_busy"}, busy, 0);
    chk({tag, ".dn_done"}, done, 1);
    step();
    chk({tag, ".idle_done"}, done, 0);
    chk({tag, ".idle_busy"}, busy, 0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    hold      = 1'b0;
    mode      = 1'b0;
    dir       = 1'b0;
    base_addr = 12'h000;
    len       = 12'h000;
`ifdef N_RD_ADDR_REPEAT_EN
    rep_cnt   = 8'd0;
`endif
    @(posedge clkin);
    chk("rst.addr", addr, 12'h000);
    chk("rst.vld", addr_vld, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    rst_n = 1'b1;
    step();

    // basic increment pass
    go(12'h100, 12'd4, 1'b0, 1'b0);
    expect_a("inc", 12'h100);
    expect_a("inc", 12'h101);
    expect_a("inc", 12'h102);
    expect_a("inc", 12'h103);
    expect_done("inc", 12'h103);

    // increment wrap
    go(12'hFFE, 12'd4, 1'b0, 1'b0);
    expect_a("wrapi", 12'hFFE);
    expect_a("wrapi", 12'hFFF);
    expect_a("wrapi", 12'h000);
    expect_a("wrapi", 12'h001);
    expect_done("wrapi", 12'h001);

    // decrement wrap
    go(12'h001, 12'd4, 1'b0, 1'b1);
    expect_a("wrapd", 12'h001);
    expect_a("wrapd", 12'h000);
    expect_a("wrapd", 12'hFFF);
    expect_a("wrapd", 12'hFFE);
    expect_done("wrapd", 12'hFFE);

    // circular until abort
    go(12'h010, 12'd3, 1'b1, 1'b0);
    for (int p = 0; p < 2; p++) begin
      expect_a("circ", 12'h010);
      expect_a("circ", 12'h011);
      expect_a("circ", 12'h012);
    end
    expect_a("circ", 12'h010);
    chk("circ.pre_abort", addr, 12'h011);
    abort = 1'b1;
    step();
    chk("abort.addr", addr, 12'h011);
    chk("abort.vld", addr_vld, 0);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    // abort beats a simultaneous start
    start = 1'b1;
    len   = 12'd4;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start.busy", busy, 0);
    chk("abort_start.done", done, 0);
    step();
    chk("abort_after.busy", busy, 0);
    chk("abort_after.done", done, 0);

    // hold for two cycles after the second address
    go(12'h100, 12'd4, 1'b0, 1'b0);
    expect_a("hold", 12'h100);
    chk("hold.a1", addr, 12'h101);
    chk("hold.v1", addr_vld, 1);
    hold = 1'b1;
    step();
    chk("hold.h1_addr", addr, 12'h101);
    chk("hold.h1_vld", addr_vld, 0);
    chk("hold.h1_busy", busy, 1);
    step();
    chk("hold.h2_addr", addr, 12'h101);
    chk("hold.h2_vld", addr_vld, 0);
    hold = 1'b0;
    step();
    expect_a("hold", 12'h102);
    expect_a("hold", 12'h103);
    expect_done("hold", 12'h103);

    // start with len=0 is ignored
    base_addr = 12'h500;
    len       = 12'd0;
    start     = 1'b1;
    step();
    start     = 1'b0;
    chk("len0.busy", busy, 0);
    chk("len0.vld", addr_vld, 0);
    chk("len0.addr", addr, 12'h103);

    // start and config changes during RUN are ignored
    go(12'h200, 12'd3, 1'b0, 1'b0);
    base_addr = 12'h300;
    len       = 12'd5;
    mode      = 1'b1;
    dir       = 1'b1;
    start     = 1'b1;
    expect_a("midrun", 12'h200);
    start     = 1'b0;
    expect_a("midrun", 12'h201);
    expect_a("midrun", 12'h202);
    expect_done("midrun", 12'h202);

    // single-address pass
    go(12'h7FF, 12'd1, 1'b0, 1'b0);
    expect_a("len1", 12'h7FF);
    expect_done("len1", 12'h7FF);

`ifdef N_RD_ADDR_REPEAT_EN
    // three passes, one done
    rep_cnt = 8'd2;
    go(12'h020, 12'd2, 1'b0, 1'b0);
    rep_cnt = 8'd0;
    for (int p = 0; p < 3; p++) begin
      expect_a("rep", 12'h020);
      expect_a("rep", 12'h021);
    end
    expect_done("rep", 12'h021);
`endif

    // reset mid-run
    go(12'h100, 12'd4, 1'b0, 1'b0);
    expect_a("rstmid", 12'h100);
    expect_a("rstmid", 12'h101);
    chk("rstmid.pre", addr, 12'h102);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid.addr", addr, 12'h000);
    chk("rstmid.vld", addr_vld, 0);
    chk("rstmid.busy", busy, 0);
    chk("rstmid.done", done, 0);
    @(posedge clkin);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rstmid.post_done", done, 0);
      chk("rstmid.post_busy", busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
